// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory line responder and the cache top level.
package dmem_pkg;

  localparam int unsigned LINE_W           = 32'd256;
  localparam int unsigned LINE_OFFSET_BITS = 32'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2,
    ST_TURN = 2'd3
  } dmem_state_e;

  // Line number of a byte address; callers truncate to their own depth so
  // out-of-range addresses wrap.
  function automatic logic [31:0] line_number(input logic [31:0] addr);
    return addr >> LINE_OFFSET_BITS;
  endfunction

endpackage

// File: rtl/dmem_line_array.sv
// Single-port synchronous line store: registered read, no reset on contents.
module dmem_line_array #(
  parameter int unsigned DEPTH_LOG2 = 32'd10,
  parameter int unsigned LINE_W     = dmem_pkg::LINE_W
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [LINE_W-1:0]     wdata,
  output logic [LINE_W-1:0]     rdata
);

  localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;

  logic [LINE_W-1:0] mem_r [0:DEPTH-1];

  // One access per enabled edge: commit a write, or register a read line
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem_r[idx] <= wdata;
      end else begin
        rdata <= mem_r[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_line_responder.sv
// Data-memory responder for cache line fills and write-backs: one request at a
// time, fixed latency, one-cycle ack pulse.
module dmem_line_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY    = 32'd10,
  parameter int unsigned DEPTH_LOG2 = 32'd10,
  parameter int unsigned LINE_W     = dmem_pkg::LINE_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              busy_o
);

  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 32'd1);

  dmem_state_e             state_r, state_s;
  logic [7:0]              cnt_r, cnt_s;
  logic                    write_r;
  logic [DEPTH_LOG2-1:0]   idx_r;
  logic [LINE_W-1:0]       wdata_r;
  logic                    ack_r, busy_r, rd_ack_r;
  logic [LINE_W-1:0]       hold_r;
  logic                    mem_en_s;
  logic [LINE_W-1:0]       rdata_s;

  // Next-state, latency countdown and the single memory access strobe
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    mem_en_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable_i) begin
          state_s = ST_WAIT;
          cnt_s   = CNT_LOAD;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r != 8'd0) begin
          cnt_s = cnt_r - 8'd1;
        end else begin
          // A reset on the access edge must not commit the pending write
          mem_en_s = ~rst_i;
          state_s  = ST_ACK;
        end
      end
      ST_ACK:  state_s = ST_TURN;
      ST_TURN: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, counter and registered handshake outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 8'd0;
      ack_r    <= 1'b0;
      busy_r   <= 1'b0;
      rd_ack_r <= 1'b0;
      hold_r   <= {LINE_W{1'b0}};
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      ack_r    <= (state_s == ST_ACK);
      busy_r   <= (state_s != ST_IDLE);
      rd_ack_r <= (state_s == ST_ACK) && !write_r;
      if (rd_ack_r) begin
        hold_r <= rdata_s;
      end
    end
  end

  // Capture the request so later input changes cannot disturb it
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      write_r <= 1'b0;
      idx_r   <= {DEPTH_LOG2{1'b0}};
      wdata_r <= {LINE_W{1'b0}};
    end else if ((state_r == ST_IDLE) && enable_i) begin
      write_r <= write_i;
      idx_r   <= DEPTH_LOG2'(line_number(addr_i));
      wdata_r <= data_i;
    end
  end

  dmem_line_array #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .LINE_W     (LINE_W)
  ) u_array (
    .clk   (clk_i),
    .en    (mem_en_s),
    .we    (write_r),
    .idx   (idx_r),
    .wdata (wdata_r),
    .rdata (rdata_s)
  );

  // The array's read register is fresh during a read ack; otherwise show the last read line
  assign data_o = rd_ack_r ? rdata_s : hold_r;
  assign ack_o  = ack_r;
  assign busy_o = busy_r;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Randomized scoreboard bench for dmem_line_responder with a line-level reference model.
module tb_dmem_line_responder;

  localparam int L   = 4;
  localparam int DL2 = 10;

  logic         clk = 1'b0;
  logic         rst, en, wr, ack, busy;
  logic [31:0]  addr;
  logic [255:0] din, dout;

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit           rd;
    logic [255:0] data;
  } exp_t;

  exp_t         sbq[$];
  logic [255:0] model [int];
  int           lines [8] = '{0, 3, 32, 5, 7, 100, 1023, 512};

  dmem_line_responder #(
    .LATENCY    (L),
    .DEPTH_LOG2 (DL2),
    .LINE_W     (256)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .enable_i (en),
    .write_i  (wr),
    .addr_i   (addr),
    .data_i   (din),
    .ack_o    (ack),
    .data_o   (dout),
    .busy_o   (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 5) % (32'd1 << DL2));
  endfunction

  function automatic logic [255:0] rand_line();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom();
    return d;
  endfunction

  function automatic logic [31:0] mk_addr(input int line);
    return ($urandom() & 32'hFFFF_8000) | (32'(line) << 5) | 32'($urandom_range(0, 31));
  endfunction

  // Scoreboard monitor: every ack must match the oldest outstanding request
  always @(negedge clk) begin : monitor
    exp_t e;
    if (ack === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        $display("FAIL unexpected_ack: ack seen with no request outstanding, required none");
      end else begin
        e = sbq.pop_front();
        if (e.rd) check("read_data", dout, e.data);
      end
    end
  end

  // Issue one request at a negedge; checks ack/busy timing for LATENCY+3 edges
  task automatic do_req(input bit w, input logic [31:0] a, input logic [255:0] d, input bit hold);
    exp_t e;
    int   ln;
    ln   = line_of(a);
    e.rd = !w;
    if (w) begin
      model[ln] = d;
      e.data    = d;
    end else begin
      e.data = model.exists(ln) ? model[ln] : 'x;
    end
    sbq.push_back(e);
    en = 1'b1; wr = w; addr = a; din = d;
    @(posedge clk);
    for (int k = 0; k <= L + 2; k++) begin
      @(negedge clk);
      check($sformatf("ack_k%0d", k), 256'(ack), 256'(k == L));
      check($sformatf("busy_k%0d", k), 256'(busy), 256'(k <= L + 1));
      if (k < L + 2) begin
        if (hold) begin
          wr = 1'($urandom()); addr = $urandom(); din = rand_line();
        end else begin
          en = 1'b0;
        end
      end
    end
  endtask

  // Write request aborted by a reset landing on edge k_rst after acceptance
  task automatic do_abort(input logic [31:0] a, input logic [255:0] d, input int k_rst);
    en = 1'b1; wr = 1'b1; addr = a; din = d;
    @(posedge clk);
    for (int k = 0; k < k_rst; k++) begin
      @(negedge clk);
      en = 1'b0;
      if (k == k_rst - 1) rst = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < L + 3; k++) begin
      check("abort_busy", 256'(busy), 256'(0));
      check("abort_ack", 256'(ack), 256'(0));
      @(negedge clk);
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    rst = 1'b1; en = 1'b0; wr = 1'b0; addr = 32'd0; din = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      check("rst_ack", 256'(ack), 256'(0));
      check("rst_busy", 256'(busy), 256'(0));
      check("rst_data", dout, 256'(0));
      @(negedge clk);
    end

    do_req(1'b1, 32'h0000_0400, a5, 1'b0);
    do_req(1'b0, 32'h0000_041C, rand_line(), 1'b0);
    do_req(1'b1, 32'h0000_8000, rand_line(), 1'b0);
    do_req(1'b0, 32'h0000_0000, rand_line(), 1'b0);
    do_req(1'b1, 32'h0000_0060, rand_line(), 1'b1);
    do_req(1'b0, 32'h0000_0060, rand_line(), 1'b1);
    do_req(1'b0, 32'h0000_0400, rand_line(), 1'b0);

    en = 1'b0;
    do_abort(32'h0000_0060, rand_line(), 2);
    do_abort(32'h0000_006F, rand_line(), L);
    do_req(1'b0, 32'h0000_0074, rand_line(), 1'b0);

    for (int i = 0; i < 8; i++)
      if (!model.exists(lines[i])) do_req(1'b1, mk_addr(lines[i]), rand_line(), 1'b0);

    for (int i = 0; i < 50; i++) begin
      en = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_req(1'($urandom()), mk_addr(lines[$urandom_range(0, 7)]), rand_line(), 1'($urandom()));
    end

    en = 1'b0;
    repeat (L + 4) @(negedge clk);
    check("sb_empty", 256'(sbq.size()), 256'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
